// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Multicycle control unit for the 4-bit MIPS core. Each instruction is
// sequenced through FETCH/DECODE/EXEC/MEM/WB. Data memory accesses wait on a
// MemReady handshake. A halt opcode parks the controller in HALT until Run is
// raised. Illegal opcodes are flagged (sticky) and retired as NOPs, and every
// retired instruction is counted.
//
// Parameters
//   OPW     opcode width (>= 3); encodings above 7 are illegal
//   ALUOPW  ALUOp width (>= 2); bits above [1:0] are driven 0
//   CNTW    retired-instruction counter width
//
// Ports
//   Clock       in   system clock, rising edge
//   Reset       in   asynchronous, active-low reset
//   OPCode      in   opcode field from the instruction register (DECODE only)
//   Zero        in   ALU zero flag (EXEC of beq only)
//   MemReady    in   data memory completes the access this cycle (MEM only)
//   Run         in   leaves HALT
//   IRWrite     out  instruction register load
//   PCWrite     out  program counter load
//   PCSrc       out  00 PC+1, 01 branch target, 10 jump target
//   Regdst      out  register destination select
//   MemRead     out  data memory read strobe
//   MemWrite    out  data memory write strobe
//   MemtoReg    out  write-back source: memory
//   RegWrite    out  register file write enable
//   ALUOp       out  00 add, 01 sub/compare, 10 slt, 11 sll
//   ALUSrc      out  00 reg, 01 imm, 10 shamt
//   Halted      out  high while in HALT
//   IllegalOp   out  sticky illegal-opcode flag, cleared only by reset
//   InstrDone   out  one-cycle pulse when an instruction retires
//   InstrCount  out  retired-instruction count, wraps
//   State       out  debug view of the state register
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int OPW    = 3,
    parameter int ALUOPW = 2,
    parameter int CNTW   = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [OPW-1:0]    OPCode,
    input  logic              Zero,
    input  logic              MemReady,
    input  logic              Run,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic [1:0]        PCSrc,
    output logic              Regdst,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic [ALUOPW-1:0] ALUOp,
    output logic [1:0]        ALUSrc,
    output logic              Halted,
    output logic              IllegalOp,
    output logic              InstrDone,
    output logic [CNTW-1:0]   InstrCount,
    output logic [2:0]        State
);

    // Debug encoding is visible on State, so the values are fixed.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_RST    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_ADDI = 3'd0,
        OP_SLL  = 3'd1,
        OP_SLT  = 3'd2,
        OP_SW   = 3'd3,
        OP_LW   = 3'd4,
        OP_BEQ  = 3'd5,
        OP_J    = 3'd6,
        OP_HALT = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        PC_PLUS1  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_SLT = 2'b10,
        ALU_SLL = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_REG   = 2'b00,
        SRC_IMM   = 2'b01,
        SRC_SHAMT = 2'b10
    } alu_src_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          state;
    state_t          state_next;
    logic [OPW-1:0]  op_reg;
    logic            illegal_q;
    logic [CNTW-1:0] count_q;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic     ir_write;
    logic     pc_write;
    pc_src_t  pc_src;
    logic     reg_dst;
    logic     mem_read;
    logic     mem_write;
    logic     mem_to_reg;
    logic     reg_write;
    alu_op_t  alu_op;
    alu_src_t alu_src;
    logic     halted;
    logic     instr_done;
    logic     set_illegal;

    // Only the low three bits name a legal instruction; anything set above
    // them is illegal. With OPW == 3 this reduces to a constant 0.
    logic op_illegal;
    op_t  dec_op;
    op_t  ex_op;

    assign op_illegal = |(OPCode >> 3);
    // DECODE acts on the live opcode; later states only see the copy that was
    // latched at the end of DECODE, so OPCode changes after DECODE are inert.
    assign dec_op     = op_t'(OPCode[2:0]);
    assign ex_op      = op_t'(op_reg[2:0]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_RST;
            op_reg    <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                op_reg <= OPCode;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (instr_done) begin
                count_q <= count_q + CNTW'(1);
            end
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_PLUS1;
        reg_dst     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_op      = ALU_ADD;
        alu_src     = SRC_REG;
        halted      = 1'b0;
        instr_done  = 1'b0;
        set_illegal = 1'b0;

        case (state)
            ST_RST: begin
                state_next = ST_FETCH;
            end

            ST_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                pc_src     = PC_PLUS1;
                state_next = ST_DECODE;
            end

            ST_DECODE: begin
                if (op_illegal) begin
                    // Retired as a NOP so software can keep running.
                    set_illegal = 1'b1;
                    instr_done  = 1'b1;
                    state_next  = ST_FETCH;
                end else begin
                    case (dec_op)
                        OP_HALT: begin
                            // PC already points past the halt; it is not
                            // advanced again on entry to HALT.
                            instr_done = 1'b1;
                            state_next = ST_HALT;
                        end
                        OP_J: begin
                            pc_write   = 1'b1;
                            pc_src     = PC_JUMP;
                            instr_done = 1'b1;
                            state_next = ST_FETCH;
                        end
                        default: begin
                            state_next = ST_EXEC;
                        end
                    endcase
                end
            end

            ST_EXEC: begin
                case (ex_op)
                    OP_ADDI: begin
                        alu_src    = SRC_IMM;
                        alu_op     = ALU_ADD;
                        state_next = ST_WB;
                    end
                    OP_SLL: begin
                        alu_src    = SRC_SHAMT;
                        alu_op     = ALU_SLL;
                        state_next = ST_WB;
                    end
                    OP_SLT: begin
                        alu_src    = SRC_REG;
                        alu_op     = ALU_SLT;
                        state_next = ST_WB;
                    end
                    OP_SW, OP_LW: begin
                        // Address = base + immediate.
                        alu_src    = SRC_IMM;
                        alu_op     = ALU_ADD;
                        state_next = ST_MEM;
                    end
                    OP_BEQ: begin
                        // Compare and branch resolve in the same cycle.
                        alu_op     = ALU_SUB;
                        pc_src     = PC_BRANCH;
                        pc_write   = Zero;
                        instr_done = 1'b1;
                        state_next = ST_FETCH;
                    end
                    default: begin
                        state_next = ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                // Address operand stays selected for the whole access.
                alu_src   = SRC_IMM;
                mem_read  = (ex_op == OP_LW);
                mem_write = (ex_op == OP_SW);
                if (MemReady) begin
                    if (ex_op == OP_LW) begin
                        state_next = ST_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
                case (ex_op)
                    OP_ADDI: begin
                        alu_src = SRC_IMM;
                    end
                    OP_SLL: begin
                        reg_dst = 1'b1;
                        alu_src = SRC_SHAMT;
                        alu_op  = ALU_SLL;
                    end
                    OP_SLT: begin
                        reg_dst = 1'b1;
                        alu_op  = ALU_SLT;
                    end
                    OP_LW: begin
                        mem_to_reg = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            ST_HALT: begin
                halted = 1'b1;
                if (Run) begin
                    state_next = ST_FETCH;
                end
            end

            default: begin
                // Unused encoding 7: recover through the reset state.
                state_next = ST_RST;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign IRWrite    = ir_write;
    assign PCWrite    = pc_write;
    assign PCSrc      = pc_src;
    assign Regdst     = reg_dst;
    assign MemRead    = mem_read;
    assign MemWrite   = mem_write;
    assign MemtoReg   = mem_to_reg;
    assign RegWrite   = reg_write;
    assign ALUOp      = ALUOPW'(alu_op);
    assign ALUSrc     = alu_src;
    assign Halted     = halted;
    assign IllegalOp  = illegal_q;
    assign InstrDone  = instr_done;
    assign InstrCount = count_q;
    assign State      = state;

    // -----------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------
    a_no_rd_wr: assert property (@(posedge Clock) disable iff (!Reset)
        !(MemRead && MemWrite));

    a_halt_quiet: assert property (@(posedge Clock) disable iff (!Reset)
        Halted |-> !(PCWrite || IRWrite || RegWrite || MemRead || MemWrite));

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//
// Directed bench for multi_cycle_ctrl. Each instruction is expanded from its
// documented cycle table into a list of per-cycle steps (inputs to drive and
// outputs expected); the steps are then played against two instances that
// differ only in counter width (8 and 2 bits). Outputs are sampled on the
// falling edge. A few literal expectations pin the cycle tables themselves.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_RST    = 3'd6;

    localparam logic [3:0] OP_ADDI = 4'd0;
    localparam logic [3:0] OP_SLL  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_LW   = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_J    = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    typedef struct packed {
        logic [2:0] state;
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       rw;
        logic [1:0] aluop;
        logic [1:0] alusrc;
        logic       halted;
        logic       done;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [3:0] op;
        logic       z;
        logic       mr;
        logic       run;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       run;

    always #5 clk = ~clk;

    // Instance A: 8-bit counter
    logic       a_irw, a_pcw, a_regdst, a_mrd, a_mwr, a_m2r, a_rw;
    logic       a_halted, a_ill, a_done;
    logic [1:0] a_pcsrc, a_aluop, a_alusrc;
    logic [7:0] a_cnt;
    logic [2:0] a_state;
    vec_t       a_vec;

    // Instance B: 2-bit counter
    logic       b_irw, b_pcw, b_regdst, b_mrd, b_mwr, b_m2r, b_rw;
    logic       b_halted, b_ill, b_done;
    logic [1:0] b_pcsrc, b_aluop, b_alusrc;
    logic [1:0] b_cnt;
    logic [2:0] b_state;
    vec_t       b_vec;

    multi_cycle_ctrl #(.OPW(4), .ALUOPW(2), .CNTW(8)) dut_a (
        .Clock(clk), .Reset(rst_n), .OPCode(opcode), .Zero(zero),
        .MemReady(mem_ready), .Run(run),
        .IRWrite(a_irw), .PCWrite(a_pcw), .PCSrc(a_pcsrc), .Regdst(a_regdst),
        .MemRead(a_mrd), .MemWrite(a_mwr), .MemtoReg(a_m2r), .RegWrite(a_rw),
        .ALUOp(a_aluop), .ALUSrc(a_alusrc), .Halted(a_halted),
        .IllegalOp(a_ill), .InstrDone(a_done), .InstrCount(a_cnt),
        .State(a_state)
    );

    multi_cycle_ctrl #(.OPW(4), .ALUOPW(2), .CNTW(2)) dut_b (
        .Clock(clk), .Reset(rst_n), .OPCode(opcode), .Zero(zero),
        .MemReady(mem_ready), .Run(run),
        .IRWrite(b_irw), .PCWrite(b_pcw), .PCSrc(b_pcsrc), .Regdst(b_regdst),
        .MemRead(b_mrd), .MemWrite(b_mwr), .MemtoReg(b_m2r), .RegWrite(b_rw),
        .ALUOp(b_aluop), .ALUSrc(b_alusrc), .Halted(b_halted),
        .IllegalOp(b_ill), .InstrDone(b_done), .InstrCount(b_cnt),
        .State(b_state)
    );

    assign a_vec = vec_t'({a_state, a_irw, a_pcw, a_pcsrc, a_regdst, a_mrd,
                           a_mwr, a_m2r, a_rw, a_aluop, a_alusrc, a_halted,
                           a_done});
    assign b_vec = vec_t'({b_state, b_irw, b_pcw, b_pcsrc, b_regdst, b_mrd,
                           b_mwr, b_m2r, b_rw, b_aluop, b_alusrc, b_halted,
                           b_done});

    // -----------------------------------------------------------------------
    // Model state and bookkeeping
    // -----------------------------------------------------------------------
    int     checks = 0;
    int     failures = 0;
    int     model_count = 0;
    logic   model_illegal = 1'b0;
    int     memread_seen = 0;
    int     memwrite_seen = 0;
    step_t  steps[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp,
                     $time);
        end
    endtask

    // A step for state st with no controls asserted. Inputs that the
    // controller must ignore in that state carry distracting values: a halt
    // opcode, Zero=1, MemReady=1 and Run=1.
    function automatic step_t blank(input logic [2:0] st);
        step_t s;
        s.v       = '0;
        s.v.state = st;
        s.op      = OP_HALT;
        s.z       = 1'b1;
        s.mr      = 1'b1;
        s.run     = 1'b1;
        return s;
    endfunction

    // Expand one instruction into its cycle sequence.
    //   z : Zero during EXEC (beq)
    //   w : MEM wait cycles before MemReady (lw/sw)
    //   n : HALT cycles; Run is 0 for the first n-1 and 1 on the last
    task automatic add_instr(input logic [3:0] op, input logic z, input int w,
                             input int n);
        step_t s;
        s = blank(S_FETCH);
        s.v.irw = 1'b1;
        s.v.pcw = 1'b1;
        steps.push_back(s);

        s = blank(S_DECODE);
        s.op = op;
        if (op > 4'd7) begin
            s.v.done = 1'b1;
            steps.push_back(s);
            return;
        end
        if (op == OP_HALT) begin
            s.v.done = 1'b1;
            steps.push_back(s);
            for (int i = 0; i < n; i++) begin
                s = blank(S_HALT);
                s.v.halted = 1'b1;
                s.run = (i == n - 1);
                steps.push_back(s);
            end
            return;
        end
        if (op == OP_J) begin
            s.v.pcw   = 1'b1;
            s.v.pcsrc = 2'b10;
            s.v.done  = 1'b1;
            steps.push_back(s);
            return;
        end
        steps.push_back(s);

        s = blank(S_EXEC);
        case (op)
            OP_ADDI, OP_SW, OP_LW: s.v.alusrc = 2'b01;
            OP_SLL: begin
                s.v.alusrc = 2'b10;
                s.v.aluop  = 2'b11;
            end
            OP_SLT: s.v.aluop = 2'b10;
            default: begin
                s.z       = z;
                s.v.aluop = 2'b01;
                s.v.pcsrc = 2'b01;
                s.v.pcw   = z;
                s.v.done  = 1'b1;
            end
        endcase
        steps.push_back(s);
        if (op == OP_BEQ) return;

        if (op == OP_SW || op == OP_LW) begin
            for (int i = 0; i <= w; i++) begin
                s = blank(S_MEM);
                s.v.alusrc = 2'b01;
                s.v.mrd    = (op == OP_LW);
                s.v.mwr    = (op == OP_SW);
                s.mr       = (i == w);
                s.v.done   = (op == OP_SW) && (i == w);
                steps.push_back(s);
            end
            if (op == OP_SW) return;
        end

        s = blank(S_WB);
        s.v.rw   = 1'b1;
        s.v.done = 1'b1;
        case (op)
            OP_ADDI: s.v.alusrc = 2'b01;
            OP_SLL: begin
                s.v.regdst = 1'b1;
                s.v.alusrc = 2'b10;
                s.v.aluop  = 2'b11;
            end
            OP_SLT: begin
                s.v.regdst = 1'b1;
                s.v.aluop  = 2'b10;
            end
            default: s.v.m2r = 1'b1;
        endcase
        steps.push_back(s);
    endtask

    task automatic compare_outputs(input vec_t v);
        check("outs_a", a_vec, v);
        check("outs_b", b_vec, v);
        check("illegal_a", a_ill, model_illegal);
        check("count_a", a_cnt, model_count % 256);
        check("count_b", b_cnt, model_count % 4);
        if (a_mrd) memread_seen++;
        if (a_mwr) memwrite_seen++;
    endtask

    // Entered just after a rising edge: drive this cycle's inputs, compare on
    // the falling edge, then advance the model across the next rising edge.
    task automatic do_step(input step_t s);
        opcode    = s.op;
        zero      = s.z;
        mem_ready = s.mr;
        run       = s.run;
        @(negedge clk);
        compare_outputs(s.v);
        @(posedge clk);
        #1;
        if (s.v.done) model_count++;
        if (s.v.state == S_DECODE && s.op > 4'd7) model_illegal = 1'b1;
    endtask

    task automatic run_steps();
        while (steps.size() > 0) do_step(steps.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   mark;
        int   wrap_exp[5];
        vec_t rst_vec;

        wrap_exp = '{1, 2, 3, 0, 1};
        rst_vec  = '0;
        rst_vec.state = S_RST;

        rst_n     = 1'b0;
        opcode    = OP_HALT;
        zero      = 1'b1;
        mem_ready = 1'b1;
        run       = 1'b1;

        // Reset held for three cycles, then one RST cycle after release.
        @(posedge clk);
        #1;
        check("reset_state_lit", a_state, 3'd6);
        repeat (3) steps.push_back(blank(S_RST));
        run_steps();
        rst_n = 1'b1;
        steps.push_back(blank(S_RST));

        // ALU ops: 4 cycles each.
        add_instr(OP_ADDI, 1'b0, 0, 0);
        add_instr(OP_SLL,  1'b0, 0, 0);
        add_instr(OP_SLT,  1'b0, 0, 0);
        run_steps();
        check("alu_count_lit", a_cnt, 3);

        // lw waiting three cycles, then sw ready at once.
        mark = memread_seen;
        add_instr(OP_LW, 1'b0, 3, 0);
        run_steps();
        check("lw_memread_cycles_lit", memread_seen - mark, 4);
        mark = memwrite_seen;
        add_instr(OP_SW, 1'b0, 0, 0);
        run_steps();
        check("sw_memwrite_cycles_lit", memwrite_seen - mark, 1);
        check("mem_count_lit", a_cnt, 5);

        // Branches and jump.
        add_instr(OP_BEQ, 1'b1, 0, 0);
        add_instr(OP_BEQ, 1'b0, 0, 0);
        add_instr(OP_J,   1'b0, 0, 0);
        run_steps();
        check("branch_count_lit", a_cnt, 8);

        // Halt for 5 idle cycles then resume; halt with Run already high;
        // an illegal opcode; then a normal instruction with the flag held.
        add_instr(OP_HALT, 1'b0, 0, 6);
        add_instr(OP_HALT, 1'b0, 0, 1);
        add_instr(4'b1010, 1'b0, 0, 0);
        run_steps();
        check("illegal_set_lit", a_ill, 1);
        add_instr(OP_ADDI, 1'b0, 0, 0);
        run_steps();
        check("illegal_sticky_lit", a_ill, 1);
        check("halt_count_a_lit", a_cnt, 12);
        check("halt_count_b_lit", b_cnt, 0);

        // Abort: reset arrives while sw waits in MEM.
        add_instr(OP_SW, 1'b0, 5, 0);
        for (int i = 0; i < 4; i++) do_step(steps.pop_front());
        steps.delete();
        check("abort_memwrite_before_lit", a_mwr, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_memwrite_lit", a_mwr, 0);
        check("abort_state_lit", a_state, 3'd6);
        check("abort_outs", a_vec, rst_vec);
        model_count   = 0;
        model_illegal = 1'b0;
        repeat (2) steps.push_back(blank(S_RST));
        run_steps();
        rst_n = 1'b1;
        steps.push_back(blank(S_RST));
        run_steps();

        // Counter wrap on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            add_instr(OP_J, 1'b0, 0, 0);
            run_steps();
            check($sformatf("wrap_count_b_%0d", i), b_cnt, wrap_exp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
